// File: rtl/mcycle_unit.sv
`default_nettype none
// ============================================================================
// Module   : mcycle_unit
// Purpose  : Iterative multi-cycle multiply/divide unit for the execute stage.
//            One shift-add (multiply) or restoring shift-subtract (divide)
//            step per cycle, WIDTH steps per operation, with the result
//            presented as two WIDTH-bit halves for register writeback.
// Ports    : CLK       - clock, rising edge
//            RESET     - synchronous active-high reset
//            Start     - operation request, sampled only in IDLE
//            MCycleOp  - 00 smul, 01 umul, 10 sdiv, 11 udiv
//            Operand1  - multiplicand / dividend
//            Operand2  - multiplier / divisor
//            Result1   - product low half / quotient (registered)
//            Result2   - product high half / remainder (registered)
//            Busy      - stall request, combinational from state and Start
// Revision : 1.0 - initial release
// ============================================================================
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPUTING = 2'd1,
    S_DONE      = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result1_q, result1_d;
  logic [WIDTH-1:0]     result2_q, result2_d;

  // Latched operation context (no reset needed: always written on accept).
  logic                 div_q, div_d;
  logic                 neg_a_q, neg_a_d;
  logic                 neg_b_q, neg_b_d;
  logic [WIDTH-1:0]     a_q, a_d;      // raw dividend, returned on divide by zero
  logic [WIDTH-1:0]     m_q, m_d;      // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0]   acc_q, acc_d;  // {high/remainder, low/quotient}

  // Operand magnitudes taken at accept time.
  logic                 w_in_signed;
  logic                 w_in_neg1, w_in_neg2;
  logic [WIDTH-1:0]     w_in_mag1, w_in_mag2;

  assign w_in_signed = ~MCycleOp[0];
  assign w_in_neg1   = w_in_signed & Operand1[WIDTH-1];
  assign w_in_neg2   = w_in_signed & Operand2[WIDTH-1];
  assign w_in_mag1   = w_in_neg1 ? (~Operand1 + 1'b1) : Operand1;
  assign w_in_mag2   = w_in_neg2 ? (~Operand2 + 1'b1) : Operand2;

  // Multiply step: conditionally add multiplicand into the high half, then
  // shift the whole accumulator right; the carry becomes the new MSB.
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_next;

  assign w_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_sum, acc_q[WIDTH-1:1]};

  // Divide step: shift the next dividend bit into the partial remainder and
  // subtract the divisor when it fits. The shifted value needs WIDTH+1 bits
  // because the remainder can reach divisor-1 >= 2^(WIDTH-1).
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_fits;
  logic [WIDTH-1:0]     w_rem_next;
  logic [2*WIDTH-1:0]   w_div_next;

  assign w_shift    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, m_q};
  assign w_fits     = (w_shift >= {1'b0, m_q});
  assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_div_next = {w_rem_next, acc_q[WIDTH-2:0], w_fits};

  logic [2*WIDTH-1:0]   w_acc_step;
  assign w_acc_step = div_q ? w_div_next : w_mul_next;

  // Sign fix-up applied to the value produced by the final step.
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo, w_rem;

  assign w_prod = (neg_a_q ^ neg_b_q) ? (~w_acc_step + 1'b1) : w_acc_step;
  assign w_quo  = (neg_a_q ^ neg_b_q) ? (~w_acc_step[WIDTH-1:0] + 1'b1)
                                      : w_acc_step[WIDTH-1:0];
  assign w_rem  = neg_a_q ? (~w_acc_step[2*WIDTH-1:WIDTH] + 1'b1)
                          : w_acc_step[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result1_d = result1_q;
    result2_d = result2_q;
    div_d     = div_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    a_d       = a_q;
    m_d       = m_q;
    acc_d     = acc_q;
    Busy      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          Busy    = 1'b1;
          state_d = S_COMPUTING;
          cnt_d   = '0;
          div_d   = MCycleOp[1];
          neg_a_d = w_in_neg1;
          neg_b_d = w_in_neg2;
          a_d     = Operand1;
          // Multiply iterates over the multiplier, divide over the dividend.
          m_d     = MCycleOp[1] ? w_in_mag2 : w_in_mag1;
          acc_d   = {{WIDTH{1'b0}}, (MCycleOp[1] ? w_in_mag1 : w_in_mag2)};
        end
      end

      S_COMPUTING: begin
        Busy  = 1'b1;
        acc_d = w_acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_STEP) begin
          state_d = S_DONE;
          if (!div_q) begin
            result1_d = w_prod[WIDTH-1:0];
            result2_d = w_prod[2*WIDTH-1:WIDTH];
          end else if (m_q == '0) begin
            result1_d = '1;
            result2_d = a_q;
          end else begin
            result1_d = w_quo;
            result2_d = w_rem;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      result1_q <= '0;
      result2_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
    end
  end

  always_ff @(posedge CLK) begin
    div_q   <= div_d;
    neg_a_q <= neg_a_d;
    neg_b_q <= neg_b_d;
    a_q     <= a_d;
    m_q     <= m_d;
    acc_q   <= acc_d;
  end

  assign Result1 = result1_q;
  assign Result2 = result2_q;

endmodule
`default_nettype wire

// File: tb/tb_mcycle_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcycle_unit
// Purpose  : Self-checking bench for mcycle_unit. A cycle-level reference
//            model derived from plain 64-bit arithmetic is compared against
//            Busy/Result1/Result2 every cycle; directed vectors carry
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcycle_unit;

  localparam int WIDTH = 32;
  localparam int STALL = WIDTH + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  op1, op2;
  logic [WIDTH-1:0]  r1, r2;
  logic              busy;

  int n_total;
  int n_pass;

  mcycle_unit #(.WIDTH(WIDTH)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .Start    (start),
    .MCycleOp (op),
    .Operand1 (op1),
    .Operand2 (op2),
    .Result1  (r1),
    .Result2  (r2),
    .Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected {Result2, Result1} for one operation, from plain arithmetic.
  function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, p;
    longint      q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin
        p = sa * sb;
        return p;
      end
      2'b01: begin
        u = {32'b0, a} * {32'b0, b};
        return u;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Reference model: an accepted operation occupies cycles c..c+WIDTH+1,
  // its results appear at the edge ending cycle c+WIDTH.
  int          cyc = 0;
  int          m_next_free = 0;
  int          m_due = 0;
  bit          m_pend = 1'b0;
  logic [63:0] m_pend_res;
  logic [31:0] m_r1 = '0, m_r2 = '0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_next_free = cyc + 1;
      m_pend      = 1'b0;
      m_r1        = '0;
      m_r2        = '0;
    end else begin
      if (m_pend && cyc == m_due) begin
        m_r1   = m_pend_res[31:0];
        m_r2   = m_pend_res[63:32];
        m_pend = 1'b0;
      end
      if (cyc >= m_next_free && start) begin
        m_pend_res  = model_res(op, op1, op2);
        m_due       = cyc + WIDTH;
        m_next_free = cyc + WIDTH + 2;
        m_pend      = 1'b1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'b0, busy},
            {31'b0, ((cyc >= m_next_free) && start) || (cyc < m_next_free - 1)});
      check("model_r1", r1, m_r1);
      check("model_r2", r2, m_r2);
    end
  end

  // Issue one operation from an IDLE cycle (called at posedge+2) and check the
  // stall length and results in the DONE cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2);
    int  cnt;
    bit  done;
    op    = o;
    op1   = a;
    op2   = b;
    start = 1'b1;
    @(negedge clk);
    check({name, "_busy0"}, {31'b0, busy}, 32'd1);
    cnt = busy ? 1 : 0;
    @(posedge clk);
    #2;
    start = 1'b0;
    op1   = $urandom;
    op2   = $urandom;
    op    = 2'($urandom_range(0, 3));
    done  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      cnt++;
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s_timeout: Busy still 1 after 100 cycles, required 0", name);
    end
    check({name, "_stall"}, cnt, STALL);
    check({name, "_r1"}, r1, e1);
    check({name, "_r2"}, r2, e2);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    op1   = '0;
    op2   = '0;
    repeat (3) @(posedge clk);
    #2;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_r1", r1, 32'd0);
    check("reset_r2", r2, 32'd0);
    @(posedge clk);
    #2;

    run_op("umul_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("smul_m3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    run_op("smul_minx2", 2'b00, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFF);
    run_op("umul_min2", 2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001);
    run_op("udiv_100_7", 2'b11, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002);
    run_op("sdiv_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("sdiv_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    run_op("udiv_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 32'h7FFF_FFFE);
    run_op("udiv_zero", 2'b11, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op("sdiv_zero", 2'b10, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF8);
    run_op("sdiv_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);

    // Start held high for 40 cycles; operands change in cycle 5.
    op    = 2'b01;
    op1   = 32'd5;
    op2   = 32'd6;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) begin
        op1 = 32'd9;
        op2 = 32'd9;
      end
      @(negedge clk);
      if (i == 33) begin
        check("hold_done_busy", {31'b0, busy}, 32'd0);
        check("hold_done_r1", r1, 32'd30);
        check("hold_done_r2", r2, 32'd0);
      end
      if (i == 34) check("hold_restart_busy", {31'b0, busy}, 32'd1);
      @(posedge clk);
      #2;
    end
    start = 1'b0;
    begin
      bit done;
      done = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (!busy) begin
          done = 1'b1;
          break;
        end
      end
      if (!done) begin
        n_total++;
        $display("FAIL hold_timeout: Busy still 1 after 100 cycles, required 0");
      end
    end
    check("hold_second_r1", r1, 32'd81);
    check("hold_second_r2", r2, 32'd0);
    @(posedge clk);
    #2;

    // Reset in cycle 10 of a multiply.
    op    = 2'b01;
    op1   = 32'hFFFF_FFFF;
    op2   = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy_before", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_r1", r1, 32'd0);
    check("rst_mid_r2", r2, 32'd0);
    @(posedge clk);
    #2;
    run_op("after_rst", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
